approx_adder_err_monitor: RTL

Sequential exhaustive error evaluator for the 8-bit approximate ripple-carry adders in this library. It drives every operand pair to an external combinational adder under test (AUT) and samples its sum. It compares each sample against the exact sum and accumulates error rate, mean-absolute-error numerator, and worst-case error with its operands. It is the consumer end of the adder interface and produces the pwr-mae figures in hardware for FPGA/emulation cross-checks of the formal results.

---
 rtl/approx_eval_pkg.sv | 16 +
 rtl/err_accumulator.sv | 61 ++++++
 rtl/approx_adder_err_monitor.sv | 100 ++++++++++
 3 files changed

// File: rtl/approx_eval_pkg.sv
// rtl/approx_eval_pkg.sv - shared constants and state type for the approximate-adder error monitor
package approx_eval_pkg;

  localparam int WIDTH  = 8;
  localparam int NPAIRS = 2 ** (2 * WIDTH);
  localparam int CNT_W  = 2 * WIDTH + 1;
  localparam int SUM_W  = 3 * WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/err_accumulator.sv
// rtl/err_accumulator.sv - stage-2 error computation and metric registers
module err_accumulator #(
  parameter int WIDTH = approx_eval_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [WIDTH:0]     sum_i,
  output logic [2*WIDTH:0]   err_count_o,
  output logic [3*WIDTH:0]   sum_abs_err_o,
  output logic [WIDTH:0]     max_err_o,
  output logic [WIDTH-1:0]   wce_a_o,
  output logic [WIDTH-1:0]   wce_b_o
);

  logic [WIDTH:0]   exact;
  logic [WIDTH:0]   abs_err;
  logic [2*WIDTH:0] err_q;
  logic [3*WIDTH:0] sum_q;
  logic [WIDTH:0]   max_q;
  logic [WIDTH-1:0] wa_q, wb_q;

  assign exact = {1'b0, a_i} + {1'b0, b_i};
  // Both operands fit WIDTH+1 unsigned, so the magnitude never needs a sign bit.
  assign abs_err = (exact >= sum_i) ? (exact - sum_i) : (sum_i - exact);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
      wa_q  <= '0;
      wb_q  <= '0;
    end else if (clear_i) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
      wa_q  <= '0;
      wb_q  <= '0;
    end else if (valid_i) begin
      err_q <= err_q + {{(2*WIDTH){1'b0}}, |abs_err};
      sum_q <= sum_q + {{(2*WIDTH){1'b0}}, abs_err};
      // Strict compare keeps the earliest pair on ties.
      if (abs_err > max_q) begin
        max_q <= abs_err;
        wa_q  <= a_i;
        wb_q  <= b_i;
      end
    end
  end

  assign err_count_o   = err_q;
  assign sum_abs_err_o = sum_q;
  assign max_err_o     = max_q;
  assign wce_a_o       = wa_q;
  assign wce_b_o       = wb_q;

endmodule

// File: rtl/approx_adder_err_monitor.sv
// rtl/approx_adder_err_monitor.sv - exhaustive operand sweep driving an external adder and collecting error metrics
module approx_adder_err_monitor #(
  parameter int WIDTH = approx_eval_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  input  logic [WIDTH:0]     aut_sum,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   err_count,
  output logic [3*WIDTH:0]   sum_abs_err,
  output logic [WIDTH:0]     max_err,
  output logic [WIDTH-1:0]   wce_a,
  output logic [WIDTH-1:0]   wce_b
);

  import approx_eval_pkg::*;

  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [PW-1:0]    pair_q, pair_d;
  logic [WIDTH-1:0] stg_a_q, stg_a_d;
  logic [WIDTH-1:0] stg_b_q, stg_b_d;
  logic [WIDTH:0]   stg_sum_q, stg_sum_d;
  logic             stg_vld_q, stg_vld_d;
  logic             clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pair_q    <= '0;
      stg_a_q   <= '0;
      stg_b_q   <= '0;
      stg_sum_q <= '0;
      stg_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      stg_a_q   <= stg_a_d;
      stg_b_q   <= stg_b_d;
      stg_sum_q <= stg_sum_d;
      stg_vld_q <= stg_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    stg_a_d   = stg_a_q;
    stg_b_d   = stg_b_q;
    stg_sum_d = stg_sum_q;
    stg_vld_d = 1'b0;
    clear     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear   = 1'b1;
          pair_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        stg_a_d   = op_a;
        stg_b_d   = op_b;
        stg_sum_d = aut_sum;
        stg_vld_d = 1'b1;
        // The counter wraps to zero on the last pair, leaving operands at 0 in DONE.
        pair_d    = pair_q + 1'b1;
        if (pair_q == '1) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign op_a = pair_q[PW-1:WIDTH];
  assign op_b = pair_q[WIDTH-1:0];
  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

  err_accumulator #(.WIDTH(WIDTH)) u_acc (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear),
    .valid_i       (stg_vld_q),
    .a_i           (stg_a_q),
    .b_i           (stg_b_q),
    .sum_i         (stg_sum_q),
    .err_count_o   (err_count),
    .sum_abs_err_o (sum_abs_err),
    .max_err_o     (max_err),
    .wce_a_o       (wce_a),
    .wce_b_o       (wce_b)
  );

endmodule
